// File: rtl/pipeline_ctrl.sv
// Pipeline control sequencer: stage write enables, flush/bubble, watchdog and sticky halt.
// Optional performance counters are built when PIPECTRL_STATS_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WDOG_MAX = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             mem_wait,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic [1:0]       state,
  output logic             deadlock,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WDOG_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ILOCK = 2'd1,
    ST_MWAIT = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              deadlock_q, deadlock_d;
  logic              halting;

  // A held HALT state is masked while reset is asserted so the RUN decode applies.
  assign halting = halt_req || ((state_q == ST_HALT) && reset);

  // Priority decode: halt > mem_wait > stall_req > branch_taken
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    state_d     = ST_RUN;
    wdog_d      = '0;
    deadlock_d  = deadlock_q;
    if (halting) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      state_d  = ST_HALT;
    end else if (mem_wait) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      state_d  = ST_MWAIT;
      wdog_d   = wdog_q;
    end else if (stall_req) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = ST_ILOCK;
      wdog_d      = (wdog_q == {WDOG_W{1'b1}}) ? wdog_q : wdog_q + WDOG_W'(1);
      if (wdog_d >= WDOG_W'(WDOG_MAX)) begin
        deadlock_d = 1'b1;
      end
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wdog_q     <= '0;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign state    = state_q;
  assign deadlock = deadlock_q;

`ifdef PIPECTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Bubbles are only ever raised by an interlock, so the bubble line is the stall event.
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(idex_bubble);
    flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
